// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter for one shared 16-way resource.
//
// A rotating priority pointer picks the next owner. The search starts just past the
// previous owner. The grant is held until the owner pulses done or drops its request.
// Each release is followed by exactly one grant-free turnaround cycle. Arbitration also
// runs in that cycle, so back-to-back owners see a one-cycle gap. All outputs are
// registered, and the asynchronous reset clears them at once.
//
// Optional feature (macro ARB_TIMEOUT_EN): a hold counter force-releases a grant after
// MAX_HOLD cycles and pulses timeout for one cycle. When the macro is undefined there
// is no hold counter and timeout is tied low.
//
// Parameters:
//   MAX_HOLD   max cycles a grant may be held (ARB_TIMEOUT_EN only), 2..2^CNT_W
//   CNT_W      width of the hold counter
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester level request, held until served
//   done       one-cycle release pulse from the current owner
//   grant      one-hot grant, all-zero when there is no owner
//   grant_idx  binary index of the owner; holds the last owner while idle
//   busy       high while a grant is active
//   timeout    one-cycle pulse when a grant is force-released
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  grant_idx,
    output logic        busy,
    output logic        timeout
);

    // Elaboration-time sanity check on the hold limit.
    if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_param_check
        $error("rr_arbiter16: MAX_HOLD must lie in 2..2^CNT_W");
    end

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  grant_idx_q, grant_idx_d;
    logic        busy_q, busy_d;
    logic [3:0]  ptr_q, ptr_d;

    logic        win_found;
    logic [3:0]  win_idx;
    logic        norm_rel;
    logic        hold_expired;

    // Rotating priority search: ptr, ptr+1, ... wrapping mod 16 through the 4-bit sum.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 0; k < 16; k++) begin
            if (!win_found && req[ptr_q + 4'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + 4'(k);
            end
        end
    end

    // Normal release: an explicit done, or the owner's request going away.
    assign norm_rel = done || !req[grant_idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    // Counter is zero on entry to GRANT and counts every cycle spent there.
    always_comb begin
        hold_cnt_d = '0;
        timeout_d  = 1'b0;
        if (state_q == StGrant) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            // A normal release in the same cycle takes precedence.
            timeout_d  = hold_expired && !norm_rel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        unique case (state_q)
            StIdle, StRelease: begin
                if (win_found) begin
                    grant_d     = 16'd1 << win_idx;
                    grant_idx_d = win_idx;
                    busy_d      = 1'b1;
                    state_d     = StGrant;
                end else begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StGrant: begin
                // Requests from non-owners are ignored here; there is no preemption.
                if (norm_rel || hold_expired) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = grant_idx_q + 4'd1;
                    state_d = StRelease;
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Testbench for rr_arbiter16: directed vectors with literal expectations, plus a
// behavioural owner/pointer model checked against the DUT on every falling clock edge.
module tb_rr_arbiter16;

    localparam int unsigned MaxHold = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req   = '0;
    logic        done  = 1'b0;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter16 #(
        .MAX_HOLD(MaxHold),
        .CNT_W   (7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_idx(grant_idx),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource (-1 = nobody), the last owner, where the next
    // search starts, and how long the current owner has held it.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tout  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit rel;
        bit forced;
        int c;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 0;
            m_ptr   = 0;
            m_hold  = 0;
            m_tout  = 1'b0;
        end else begin
            m_tout = 1'b0;
            if (m_owner >= 0) begin
                rel    = done || !req[m_owner];
                forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
                forced = !rel && (m_hold == int'(MaxHold) - 1);
`endif
                if (rel || forced) begin
                    m_ptr   = (m_owner + 1) % 16;
                    m_owner = -1;
                    m_tout  = forced;
                end else begin
                    m_hold++;
                end
            end else begin
                for (int k = 0; k < 16; k++) begin
                    c = (m_ptr + k) % 16;
                    if (m_owner < 0 && req[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_hold  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] eg;
        eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_grant_idx", 32'(grant_idx), 32'(m_last));
        chk("model_busy", 32'(busy), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_tout));
        chk("onehot0_grant", 32'($onehot0(grant)), 32'd1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        tick;
        tick;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_idx", 32'(grant_idx), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;

        // Single requester, done pulse, one-cycle gap, then regrant.
        req = 16'h0001;
        tick;
        chk("t1_grant", 32'(grant), 32'h0001);
        chk("t1_idx", 32'(grant_idx), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("t1_gap_grant", 32'(grant), 32'h0);
        chk("t1_gap_busy", 32'(busy), 32'h0);
        tick;
        chk("t1_regrant", 32'(grant), 32'h0001);
        req = '0;
        tick;
        tick;

        // Everyone requesting: full rotation 0..15 then back to 0.
        do_reset;
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            tick;
            chk("t2_idx", 32'(grant_idx), 32'(i % 16));
            chk("t2_grant", 32'(grant), 32'h1 << (i % 16));
            done = 1'b1;
            tick;
            done = 1'b0;
            chk("t2_gap", 32'(busy), 32'h0);
        end
        req = '0;
        tick;

        // Wrap: last owner 15, then 0 wins before 15.
        do_reset;
        req = 16'h8000;
        tick;
        chk("t3_first15", 32'(grant_idx), 32'd15);
        req = '0;
        tick;
        chk("t3_released", 32'(busy), 32'h0);
        req = 16'h8001;
        tick;
        chk("t3_wrap0", 32'(grant_idx), 32'd0);
        done = 1'b1;
        tick;
        done = 1'b0;
        tick;
        chk("t3_then15", 32'(grant_idx), 32'd15);
        // done and request drop together count as one release.
        done = 1'b1;
        req  = '0;
        tick;
        done = 1'b0;
        chk("t3_dual_rel", 32'(busy), 32'h0);
        tick;
        chk("t3_idle", 32'(busy), 32'h0);

        // Hold limit (or indefinite hold in the default build).
        do_reset;
        req = 16'h0020;
        tick;
        chk("t4_grant", 32'(grant), 32'h0020);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t4_held", 32'(grant), 32'h0020);
            chk("t4_no_tout", 32'(timeout), 32'h0);
        end
        tick;
        chk("t4_tout", 32'(timeout), 32'h1);
        chk("t4_tout_grant", 32'(grant), 32'h0);
        tick;
        chk("t4_regrant", 32'(grant_idx), 32'd5);
        chk("t4_tout_clear", 32'(timeout), 32'h0);
`else
        for (int i = 0; i < 10; i++) begin
            // Non-owner bits toggle; the owner keeps the grant.
            req = (i % 2 == 0) ? 16'h0121 : 16'h0020;
            tick;
            chk("t4_held", 32'(grant), 32'h0020);
            chk("t4_no_tout", 32'(timeout), 32'h0);
        end
`endif
        req = '0;
        tick;
        tick;

        // Owner drops request; next search starts at 4, so 9 beats 2.
        do_reset;
        req = 16'h0008;
        tick;
        chk("t5_idx3", 32'(grant_idx), 32'd3);
        req = '0;
        tick;
        chk("t5_drop", 32'(grant), 32'h0);
        req = 16'h0204;
        tick;
        chk("t5_idx9", 32'(grant_idx), 32'd9);
        done = 1'b1;
        req  = '0;
        tick;
        done = 1'b0;
        tick;
        // done while nothing is granted is ignored.
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("t5_idle_done", 32'(busy), 32'h0);

        // Asynchronous reset mid-grant, between clock edges.
        req = 16'h0004;
        tick;
        chk("t6_idx2", 32'(grant_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_idx", 32'(grant_idx), 32'h0);
        rst_n = 1'b1;
        req   = 16'h0100;
        tick;
        chk("t6_idx8", 32'(grant_idx), 32'd8);
        chk("t6_grant8", 32'(grant), 32'h0100);
        done = 1'b1;
        tick;
        done = 1'b0;
        req  = '0;
        tick;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
